// File: rtl/instr_sequencer.sv
// Instruction-level sequencer for the 4-bit CPU: latches OPR/OPA nibbles, tracks
// one/two-word instructions and issues PC-load, stack push/pop and execute strobes.
module instr_sequencer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CYC_M1 = 3,
    parameter int unsigned CYC_M2 = 4,
    parameter int unsigned CYC_X2 = 6,
    parameter int unsigned CYC_X3 = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        cycle,
    input  logic [3:0]        romNibble,
    input  logic [ADDR_W-1:0] pcAddr,
    input  logic              ccTrue,
    input  logic              iszZero,
    input  logic [7:0]        regPair,
    input  logic [ADDR_W-1:0] stackTop,
    output logic [3:0]        opr,
    output logic [3:0]        opa,
    output logic [3:0]        opr2,
    output logic [3:0]        opa2,
    output logic              secondWord,
    output logic              execStrobe,
    output logic              pcLoad,
    output logic [ADDR_W-1:0] pcNew,
    output logic              stackPush,
    output logic [ADDR_W-1:0] pushAddr,
    output logic              stackPop
);

    localparam int unsigned PAGE_LO = 8;
    localparam logic [2:0]  CYC_A1  = 3'd0;
    localparam logic [2:0]  CYC_X1  = 3'd5;

    localparam logic [0:0] WORD1 = 1'b0;
    localparam logic [0:0] WORD2 = 1'b1;

    localparam logic [3:0] OP_JCN = 4'h1;
    localparam logic [3:0] OP_FIM = 4'h2;
    localparam logic [3:0] OP_JIN = 4'h3;
    localparam logic [3:0] OP_JUN = 4'h4;
    localparam logic [3:0] OP_JMS = 4'h5;
    localparam logic [3:0] OP_ISZ = 4'h7;
    localparam logic [3:0] OP_BBL = 4'hC;

    logic [0:0]        state;
    logic [0:0]        nextState;
    logic              wordValid;
    logic              ccFlag;
    logic              iszFlag;
    logic              twoWord;
    logic              isM1;
    logic              isM2;
    logic              isX1;
    logic              isX2;
    logic              isX3;
    logic [ADDR_W-1:0] nextAddr;
    logic [ADDR_W-1:0] longTarget;
    logic [ADDR_W-1:0] pageTarget;
    logic [ADDR_W-1:0] jinTarget;
    logic              execNext;
    logic              loadNext;
    logic              pushNext;
    logic              popNext;
    logic [ADDR_W-1:0] pcNewNext;
    logic [ADDR_W-1:0] pushAddrNext;

    assign isM1 = (cycle == 3'(CYC_M1));
    assign isM2 = (cycle == 3'(CYC_M2));
    assign isX1 = (cycle == CYC_X1);
    assign isX2 = (cycle == 3'(CYC_X2));
    assign isX3 = (cycle == 3'(CYC_X3));

    // Jump targets: short jumps stay on the page of the word after the instruction
    assign nextAddr   = pcAddr + ADDR_W'(1);
    assign longTarget = ADDR_W'({opa, opr2, opa2});
    assign pageTarget = {nextAddr[ADDR_W-1:PAGE_LO], opr2, opa2};
    assign jinTarget  = {nextAddr[ADDR_W-1:PAGE_LO], regPair};

    always_comb begin
        twoWord = 1'b0;
        case (opr)
            OP_JCN, OP_JUN, OP_JMS, OP_ISZ: twoWord = 1'b1;
            OP_FIM:                         twoWord = ~opa[0];
            default:                        twoWord = 1'b0;
        endcase
    end

    // State register; wordValid blocks pulses until a fresh word starts after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WORD1;
            wordValid <= 1'b0;
        end else begin
            state     <= nextState;
            wordValid <= wordValid | (cycle == CYC_A1);
        end
    end

    always_comb begin
        nextState    = state;
        execNext     = 1'b0;
        loadNext     = 1'b0;
        pushNext     = 1'b0;
        popNext      = 1'b0;
        pcNewNext    = pcNew;
        pushAddrNext = pushAddr;
        if (wordValid) begin
            case (state)
                WORD1: begin
                    if (isX1 && !twoWord) begin
                        execNext = 1'b1;
                    end
                    if (isX3) begin
                        if (twoWord) begin
                            nextState = WORD2;
                        end else if (opr == OP_JIN && opa[0]) begin
                            loadNext  = 1'b1;
                            pcNewNext = jinTarget;
                        end else if (opr == OP_BBL) begin
                            loadNext  = 1'b1;
                            popNext   = 1'b1;
                            pcNewNext = stackTop;
                        end
                    end
                end
                WORD2: begin
                    if (isX1) begin
                        execNext = 1'b1;
                    end
                    if (isX3) begin
                        nextState = WORD1;
                        case (opr)
                            OP_JUN: begin
                                loadNext  = 1'b1;
                                pcNewNext = longTarget;
                            end
                            OP_JMS: begin
                                loadNext     = 1'b1;
                                pushNext     = 1'b1;
                                pcNewNext    = longTarget;
                                pushAddrNext = nextAddr;
                            end
                            OP_JCN: begin
                                loadNext  = ccFlag;
                                pcNewNext = ccFlag ? pageTarget : pcNew;
                            end
                            OP_ISZ: begin
                                loadNext  = ~iszFlag;
                                pcNewNext = iszFlag ? pcNew : pageTarget;
                            end
                            default: begin
                                loadNext = 1'b0;
                            end
                        endcase
                    end
                end
                default: nextState = WORD1;
            endcase
        end
    end

    // Nibble latches, condition flags and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            opr        <= 4'h0;
            opa        <= 4'h0;
            opr2       <= 4'h0;
            opa2       <= 4'h0;
            ccFlag     <= 1'b0;
            iszFlag    <= 1'b0;
            secondWord <= 1'b0;
            execStrobe <= 1'b0;
            pcLoad     <= 1'b0;
            stackPush  <= 1'b0;
            stackPop   <= 1'b0;
            pcNew      <= '0;
            pushAddr   <= '0;
        end else begin
            if (isM1) begin
                if (state == WORD1) begin
                    opr <= romNibble;
                end else begin
                    opr2 <= romNibble;
                end
            end
            if (isM2) begin
                if (state == WORD1) begin
                    opa <= romNibble;
                end else begin
                    opa2 <= romNibble;
                end
            end
            if (isX2) begin
                ccFlag  <= ccTrue;
                iszFlag <= iszZero;
            end
            secondWord <= (nextState == WORD2);
            execStrobe <= execNext;
            pcLoad     <= loadNext;
            stackPush  <= pushNext;
            stackPop   <= popNext;
            pcNew      <= pcNewNext;
            pushAddr   <= pushAddrNext;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: word-level ISA model plus per-cycle comparison.
`timescale 1ns/1ps
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cycle;
    logic [3:0]  romNibble;
    logic [11:0] pcAddr;
    logic        ccTrue;
    logic        iszZero;
    logic [7:0]  regPair;
    logic [11:0] stackTop;
    logic [3:0]  opr, opa, opr2, opa2;
    logic        secondWord, execStrobe, pcLoad, stackPush, stackPop;
    logic [11:0] pcNew, pushAddr;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .cycle(cycle), .romNibble(romNibble), .pcAddr(pcAddr),
        .ccTrue(ccTrue), .iszZero(iszZero), .regPair(regPair), .stackTop(stackTop),
        .opr(opr), .opa(opa), .opr2(opr2), .opa2(opa2), .secondWord(secondWord),
        .execStrobe(execStrobe), .pcLoad(pcLoad), .pcNew(pcNew), .stackPush(stackPush),
        .pushAddr(pushAddr), .stackPop(stackPop)
    );

    int errors = 0;
    int checks = 0;

    // Expected outputs after the current edge
    logic [3:0]  eOpr = 0, eOpa = 0, eOpr2 = 0, eOpa2 = 0;
    logic        eSecond = 0, eExec = 0, eLoad = 0, ePush = 0, ePop = 0;
    logic [11:0] eNew = 0, ePushAddr = 0;
    bit          eChkNew = 0, eChkPush = 0;
    bit          checkEn = 0;

    // Instruction-level model state
    bit          mInSecond = 0;
    logic [7:0]  mFirst = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit isTwo(input logic [7:0] b);
        case (b[7:4])
            4'h1, 4'h4, 4'h5, 4'h7: return 1'b1;
            4'h2:                   return !b[0];
            default:                return 1'b0;
        endcase
    endfunction

    task automatic zeroExp();
        eOpr = 0; eOpa = 0; eOpr2 = 0; eOpa2 = 0;
        eSecond = 0; eExec = 0; eLoad = 0; ePush = 0; ePop = 0;
        eNew = 0; ePushAddr = 0; eChkNew = 1; eChkPush = 1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (checkEn) begin
                chk("opr", 32'(opr), 32'(eOpr));
                chk("opa", 32'(opa), 32'(eOpa));
                chk("opr2", 32'(opr2), 32'(eOpr2));
                chk("opa2", 32'(opa2), 32'(eOpa2));
                chk("secondWord", 32'(secondWord), 32'(eSecond));
                chk("execStrobe", 32'(execStrobe), 32'(eExec));
                chk("pcLoad", 32'(pcLoad), 32'(eLoad));
                chk("stackPush", 32'(stackPush), 32'(ePush));
                chk("stackPop", 32'(stackPop), 32'(ePop));
                if (eChkNew) chk("pcNew", 32'(pcNew), 32'(eNew));
                if (eChkPush) chk("pushAddr", 32'(pushAddr), 32'(ePushAddr));
            end
        end
    end

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            cycle = 3'(6 + i);
            romNibble = 4'($urandom);
            zeroExp();
            @(posedge clk);
        end
        mInSecond = 0;
        #2;
    endtask

    // One 8-phase ROM word; abortAt (0..7) asserts rst on that phase, 8 = none
    task automatic runWord(input logic [7:0] b, input logic [11:0] addr, input bit cc,
                           input bit isz, input logic [7:0] rp, input logic [11:0] st,
                           input int abortAt);
        bit second = mInSecond;
        bit aborted = 0;
        logic [11:0] nextA = addr + 12'd1;
        logic [11:0] target;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cycle = 3'(c);
            pcAddr = addr;
            regPair = rp;
            romNibble = (c == 3) ? b[7:4] : (c == 4) ? b[3:0] : 4'($urandom);
            ccTrue = (c == 6) ? cc : !cc;
            iszZero = (c == 6) ? isz : !isz;
            stackTop = (c == 7) ? st : ~st;
            rst = (c == abortAt);
            eExec = 0; eLoad = 0; ePush = 0; ePop = 0; eChkNew = 0; eChkPush = 0;
            if (rst) begin
                zeroExp();
                second = 0;
                aborted = 1;
            end else begin
                if (c == 3) begin
                    if (second) eOpr2 = b[7:4]; else eOpr = b[7:4];
                end
                if (c == 4) begin
                    if (second) eOpa2 = b[3:0]; else eOpa = b[3:0];
                end
                eSecond = second;
                if (!aborted) begin
                    eExec = (c == 5) && (second || !isTwo(b));
                    if (c == 7) begin
                        eSecond = !second && isTwo(b);
                        target = {nextA[11:8], b};
                        if (second) begin
                            case (mFirst[7:4])
                                4'h4: begin eLoad = 1; eNew = {mFirst[3:0], b}; end
                                4'h5: begin
                                    eLoad = 1; ePush = 1;
                                    eNew = {mFirst[3:0], b}; ePushAddr = nextA;
                                end
                                4'h1: begin eLoad = cc; eNew = target; end
                                4'h7: begin eLoad = !isz; eNew = target; end
                                default: ;
                            endcase
                        end else if (!isTwo(b)) begin
                            if (b[7:4] == 4'h3 && b[0]) begin
                                eLoad = 1; eNew = {nextA[11:8], rp};
                            end
                            if (b[7:4] == 4'hC) begin
                                eLoad = 1; ePop = 1; eNew = st;
                            end
                        end
                        eChkNew = eLoad;
                        eChkPush = ePush;
                    end
                end
            end
            @(posedge clk);
        end
        if (!aborted && !second && isTwo(b)) begin
            mInSecond = 1;
            mFirst = b;
        end else begin
            mInSecond = 0;
        end
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cycle = 0; romNibble = 0; pcAddr = 0; ccTrue = 0;
        iszZero = 0; regPair = 0; stackTop = 0;
        checkEn = 1;
        doReset(2);

        // LDM one-word: first latch after reset
        runWord(8'hD3, 12'h010, 0, 0, 8'h00, 12'h000, 8);
        chk("ldm_opr", 32'(opr), 32'h0000000D);
        chk("ldm_opa", 32'(opa), 32'h00000003);

        // JUN 0x321
        runWord(8'h43, 12'h020, 0, 0, 8'h00, 12'h000, 8);
        chk("jun_second", 32'(secondWord), 32'h1);
        runWord(8'h21, 12'h021, 0, 0, 8'h00, 12'h000, 8);
        chk("jun_load", 32'(pcLoad), 32'h1);
        chk("jun_target", 32'(pcNew), 32'h321);
        chk("jun_nopush", 32'(stackPush), 32'h0);

        // JMS with second word at page end
        runWord(8'h51, 12'h0FE, 0, 0, 8'h00, 12'h000, 8);
        runWord(8'h23, 12'h0FF, 0, 0, 8'h00, 12'h000, 8);
        chk("jms_push", 32'(stackPush), 32'h1);
        chk("jms_ret", 32'(pushAddr), 32'h100);
        chk("jms_target", 32'(pcNew), 32'h123);

        // JCN false / true / page crossing / address wrap
        runWord(8'h14, 12'h050, 1, 0, 8'h00, 12'h000, 8);
        runWord(8'h80, 12'h051, 0, 0, 8'h00, 12'h000, 8);
        chk("jcn_false", 32'(pcLoad), 32'h0);
        runWord(8'h1A, 12'h2FD, 0, 0, 8'h00, 12'h000, 8);
        runWord(8'h80, 12'h2FE, 1, 0, 8'h00, 12'h000, 8);
        chk("jcn_same_page", 32'(pcNew), 32'h280);
        runWord(8'h1A, 12'h2FE, 0, 0, 8'h00, 12'h000, 8);
        runWord(8'h80, 12'h2FF, 1, 0, 8'h00, 12'h000, 8);
        chk("jcn_next_page", 32'(pcNew), 32'h380);
        runWord(8'h12, 12'hFFE, 0, 0, 8'h00, 12'h000, 8);
        runWord(8'h34, 12'hFFF, 1, 0, 8'h00, 12'h000, 8);
        chk("jcn_wrap", 32'(pcNew), 32'h034);

        // BBL, FIM, SRC
        runWord(8'hC5, 12'h060, 0, 0, 8'h00, 12'h456, 8);
        chk("bbl_pop", 32'(stackPop), 32'h1);
        chk("bbl_target", 32'(pcNew), 32'h456);
        runWord(8'h20, 12'h070, 1, 0, 8'h00, 12'h000, 8);
        runWord(8'hAB, 12'h071, 1, 0, 8'h00, 12'h000, 8);
        chk("fim_opr2", 32'(opr2), 32'h0000000A);
        chk("fim_opa2", 32'(opa2), 32'h0000000B);
        chk("fim_noload", 32'(pcLoad), 32'h0);
        runWord(8'h21, 12'h072, 1, 0, 8'h00, 12'h000, 8);

        // ISZ taken / not taken
        runWord(8'h73, 12'h3FE, 0, 0, 8'h00, 12'h000, 8);
        runWord(8'h40, 12'h3FF, 0, 0, 8'h00, 12'h000, 8);
        chk("isz_taken", 32'(pcNew), 32'h440);
        runWord(8'h73, 12'h3FE, 0, 1, 8'h00, 12'h000, 8);
        runWord(8'h40, 12'h3FF, 0, 1, 8'h00, 12'h000, 8);
        chk("isz_not_taken", 32'(pcLoad), 32'h0);

        // JIN at top of memory wraps to page 0; FIN does nothing
        runWord(8'h35, 12'hFFF, 0, 0, 8'h9C, 12'h000, 8);
        chk("jin_target", 32'(pcNew), 32'h09C);
        runWord(8'h34, 12'h080, 0, 0, 8'h9C, 12'h000, 8);

        // Reset during JUN word 2, then LDM as a fresh one-word instruction
        runWord(8'h43, 12'h100, 0, 0, 8'h00, 12'h000, 8);
        runWord(8'h21, 12'h101, 0, 0, 8'h00, 12'h000, 4);
        chk("abort_second", 32'(secondWord), 32'h0);
        chk("abort_noload", 32'(pcLoad), 32'h0);
        runWord(8'hD3, 12'h102, 0, 0, 8'h00, 12'h000, 8);
        chk("post_abort_opr", 32'(opr), 32'h0000000D);

        checkEn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
